// File: rtl/dma_channel_scheduler.sv
// dma_channel_scheduler: round-robin owner selection for a single DMA engine
// shared by NUM_CH requesting channels. The granted channel's descriptor is
// latched and presented to the engine. Start is held until the write master
// reports done, and completion is then returned to the owning channel.
// Optional feature macro: DMA_SCHED_TIMEOUT_EN. When it is defined, a watchdog
// aborts a RUN phase that lasts TIMEOUT_CYCLES cycles.
module dma_channel_scheduler #(
    parameter int NUM_CH         = 4,
    parameter int CH_W           = 2,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                iClk,
    input  logic                iReset,
    input  logic [NUM_CH-1:0]   iReq,
    input  logic [32*NUM_CH-1:0] iSrc,
    input  logic [32*NUM_CH-1:0] iDst,
    input  logic [32*NUM_CH-1:0] iLen,
    output logic [NUM_CH-1:0]   oAck,
    output logic [NUM_CH-1:0]   oDone,
    output logic [NUM_CH-1:0]   oTimeout,
    output logic                oBusy,
    output logic [CH_W-1:0]     oGrant,
    output logic [31:0]         oRM_startaddress,
    output logic [31:0]         oWM_startaddress,
    output logic [31:0]         oLength,
    output logic                oStart,
    input  logic                iWM_done
);

    typedef enum logic [1:0] {IDLE, LAUNCH, RUN, COMPLETE} state_t;

    state_t            state_q;
    state_t            state_d;
    logic [CH_W-1:0]   last_q;
    logic [CH_W-1:0]   grant_q;
    logic [31:0]       src_q;
    logic [31:0]       dst_q;
    logic [31:0]       len_q;
    logic [31:0]       src_a [NUM_CH];
    logic [31:0]       dst_a [NUM_CH];
    logic [31:0]       len_a [NUM_CH];
    logic              pick_vld;
    logic [CH_W-1:0]   pick_idx;
    logic [CH_W-1:0]   cand;
    logic [NUM_CH-1:0] grant_oh;
    logic              wd_hit;

    // Unpack the flat descriptor buses into per-channel words
    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            src_a[k] = iSrc[32*k +: 32];
            dst_a[k] = iDst[32*k +: 32];
            len_a[k] = iLen[32*k +: 32];
        end
    end

    // Round-robin pick: the nearest requester after last wins (descending scan so the smallest offset lands last)
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int i = NUM_CH; i >= 1; i--) begin
            cand = CH_W'((int'(last_q) + i) % NUM_CH);
            if (iReq[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    // One-hot form of the current owner, used by every per-channel pulse
    always_comb begin
        grant_oh          = '0;
        grant_oh[grant_q] = 1'b1;
    end

`ifdef DMA_SCHED_TIMEOUT_EN
    logic [31:0]       wd_cnt_q;
    logic [NUM_CH-1:0] to_q;

    assign wd_hit   = (wd_cnt_q == 32'(TIMEOUT_CYCLES - 1));
    assign oTimeout = to_q;

    // Watchdog: count RUN cycles and pulse the owner's timeout on abort (a done in the same cycle wins)
    always_ff @(posedge iClk) begin
        if (iReset) begin
            wd_cnt_q <= '0;
            to_q     <= '0;
        end else begin
            to_q <= '0;
            if (state_q == LAUNCH) begin
                wd_cnt_q <= '0;
            end else if (state_q == RUN) begin
                wd_cnt_q <= wd_cnt_q + 32'd1;
                if (!iWM_done && wd_hit) begin
                    to_q <= grant_oh;
                end
            end
        end
    end
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
    assign wd_hit             = 1'b0;
    assign oTimeout           = '0;
`endif

    // Next-state logic; a zero length skips the engine and goes straight to completion
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (pick_vld) state_d = LAUNCH;
            LAUNCH:   state_d = (len_q == '0) ? COMPLETE : RUN;
            RUN: begin
                if (iWM_done)    state_d = COMPLETE;
                else if (wd_hit) state_d = IDLE;
            end
            COMPLETE: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // State, owner, round-robin pointer and descriptor latches
    always_ff @(posedge iClk) begin
        if (iReset) begin
            state_q <= IDLE;
            last_q  <= CH_W'(NUM_CH - 1);
            grant_q <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && pick_vld) begin
                grant_q <= pick_idx;
                src_q   <= src_a[pick_idx];
                dst_q   <= dst_a[pick_idx];
                len_q   <= len_a[pick_idx];
            end
            if (state_q == COMPLETE || (state_q == RUN && !iWM_done && wd_hit)) begin
                last_q <= grant_q;
            end
        end
    end

    // Handshake pulses and the engine go-level decode directly from the state
    assign oAck             = (state_q == LAUNCH)   ? grant_oh : '0;
    assign oDone            = (state_q == COMPLETE) ? grant_oh : '0;
    assign oStart           = (state_q == RUN);
    assign oBusy            = (state_q != IDLE);
    assign oGrant           = grant_q;
    assign oRM_startaddress = src_q;
    assign oWM_startaddress = dst_q;
    assign oLength          = len_q;

endmodule

// File: tb/tb_dma_channel_scheduler.sv
// Bench for dma_channel_scheduler: directed channel/engine scenarios, a
// transaction-age model of the expected outputs checked every cycle, and
// literal expectations for the key latencies and grant orders.
module tb_dma_channel_scheduler;

    localparam int NUM_CH = 4;
`ifdef DMA_SCHED_TIMEOUT_EN
    localparam int TO_EN = 1;
    localparam int TO    = 20;
`else
    localparam int TO_EN = 0;
    localparam int TO    = 65535;
`endif

    logic         clk = 1'b0;
    logic         iReset = 1'b1;
    logic [3:0]   iReq = '0;
    logic [127:0] iSrc = '0;
    logic [127:0] iDst = '0;
    logic [127:0] iLen = '0;
    logic         iWM_done = 1'b0;
    logic [3:0]   oAck, oDone, oTimeout;
    logic         oBusy, oStart;
    logic [1:0]   oGrant;
    logic [31:0]  oRM, oWM, oLength;

    dma_channel_scheduler #(.NUM_CH(NUM_CH), .CH_W(2), .TIMEOUT_CYCLES(TO)) dut (
        .iClk(clk), .iReset(iReset), .iReq(iReq), .iSrc(iSrc), .iDst(iDst), .iLen(iLen),
        .oAck(oAck), .oDone(oDone), .oTimeout(oTimeout), .oBusy(oBusy), .oGrant(oGrant),
        .oRM_startaddress(oRM), .oWM_startaddress(oWM), .oLength(oLength),
        .oStart(oStart), .iWM_done(iWM_done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int oh2i(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return -1;
    endfunction

    // ---------------- behavioural model: one transaction tracked by its age
    int          m_busy = 0, m_ch = 0, m_age = 0, m_fin = -1, m_last = NUM_CH - 1, m_to = -1;
    logic [31:0] m_src = '0, m_dst = '0, m_len = '0;
    int          c;
    bit          started;

    always @(posedge clk) begin
        m_to = -1;
        if (iReset) begin
            m_busy = 0; m_last = NUM_CH - 1; m_fin = -1; m_age = 0;
            m_src = '0; m_dst = '0; m_len = '0;
        end else if (m_busy == 0) begin
            for (int i = 1; i <= NUM_CH; i++) begin
                c = (m_last + i) % NUM_CH;
                if (iReq[c] && m_busy == 0) begin
                    m_busy = 1; m_ch = c; m_age = 0;
                    m_src = iSrc[32*c +: 32]; m_dst = iDst[32*c +: 32]; m_len = iLen[32*c +: 32];
                    m_fin = (m_len == 0) ? 1 : -1;
                end
            end
        end else begin
            started = (m_len != 0) && (m_fin < 0) && (m_age >= 1);
            if (m_fin >= 0 && m_age == m_fin) begin
                m_busy = 0; m_last = m_ch;
            end else if (started && iWM_done) begin
                m_age++; m_fin = m_age;
            end else if (TO_EN == 1 && started && m_age == TO) begin
                m_busy = 0; m_last = m_ch; m_to = m_ch;
            end else begin
                m_age++;
            end
        end
    end

    logic [3:0] e_ack, e_done, e_to;
    logic       e_start;

    // compare process: every output against the model, away from the active edge
    always @(negedge clk) begin
        e_ack   = (m_busy == 1 && m_age == 0) ? 4'(1 << m_ch) : 4'b0;
        e_done  = (m_busy == 1 && m_fin >= 0 && m_age == m_fin) ? 4'(1 << m_ch) : 4'b0;
        e_to    = (m_to >= 0) ? 4'(1 << m_to) : 4'b0;
        e_start = (m_busy == 1) && (m_len != 0) && (m_fin < 0) && (m_age >= 1);
        chk("m_ack", 32'(oAck), 32'(e_ack));
        chk("m_done", 32'(oDone), 32'(e_done));
        chk("m_timeout", 32'(oTimeout), 32'(e_to));
        chk("m_busy", 32'(oBusy), 32'(m_busy));
        chk("m_start", 32'(oStart), 32'(e_start));
        if (m_busy == 1) chk("m_grant", 32'(oGrant), 32'(m_ch));
        if (e_start) begin
            chk("m_rm", oRM, m_src);
            chk("m_wm", oWM, m_dst);
            chk("m_len", oLength, m_len);
        end
    end

    // ---------------- stimulus helpers: requesters and a simple engine
    int cyc = 0;
    bit auto_drop = 1'b1;
    bit eng_en = 1'b1;
    int eng_lat = 10;
    int eng_cnt = 0;

    task automatic step();
        @(posedge clk); #1;
        cyc++;
        if (auto_drop) for (int k = 0; k < 4; k++) if (oAck[k]) iReq[k] = 1'b0;
        if (eng_en) begin
            if (oStart) eng_cnt++; else eng_cnt = 0;
            iWM_done = oStart && (eng_cnt == eng_lat);
        end
    endtask

    task automatic set_desc(input int k, input logic [31:0] s, input logic [31:0] d, input logic [31:0] l);
        iSrc[32*k +: 32] = s;
        iDst[32*k +: 32] = d;
        iLen[32*k +: 32] = l;
    endtask

    task automatic do_reset();
        iReset = 1'b1; iReq = '0; iWM_done = 1'b0;
        step(); step();
        iReset = 1'b0;
        step();
    endtask

    int st, n, dn, a1, t_s, t_to;
    int order [5];
    int exp2 [5] = '{0, 1, 2, 3, 0};
    logic [3:0] seen;

    initial begin
        // reset state
        iReset = 1'b1;
        step(); step(); step();
        chk("rst_busy", 32'(oBusy), 0);
        chk("rst_ack", 32'(oAck), 0);
        chk("rst_done", 32'(oDone), 0);
        chk("rst_start", 32'(oStart), 0);
        chk("rst_grant", 32'(oGrant), 0);
        chk("rst_rm", oRM, 0);
        chk("rst_len", oLength, 0);
        iReset = 1'b0;
        step();

        // single transfer on channel 0
        set_desc(0, 32'h1000, 32'h2000, 32'd64);
        eng_lat = 10;
        iReq = 4'b0001;
        step();
        chk("t1_ack", 32'(oAck), 32'h1);
        step();
        chk("t1_start", 32'(oStart), 1);
        chk("t1_rm", oRM, 32'h1000);
        chk("t1_wm", oWM, 32'h2000);
        chk("t1_len", oLength, 32'd64);
        st = 1;
        for (int i = 0; i < 60; i++) begin
            step();
            if (oStart) st++;
            if (oDone != 0) break;
        end
        chk("t1_done", 32'(oDone), 32'h1);
        chk("t1_start_drop", 32'(oStart), 0);
        chk("t1_start_cycles", 32'(st), 32'd10);
        step();
        chk("t1_idle", 32'(oBusy), 0);

        // all four channels held: round-robin order from reset
        do_reset();
        for (int k = 0; k < 4; k++) set_desc(k, 32'h100 * (k + 1), 32'h8000 + 32'h10 * k, 32'd16 * (k + 1));
        eng_lat = 5; auto_drop = 1'b0; n = 0; dn = 0;
        iReq = 4'b1111;
        for (int i = 0; i < 200 && dn < 5; i++) begin
            step();
            if (oAck != 0 && n < 5) begin
                order[n] = oh2i(oAck); n++;
                if (n == 5) iReq = '0;
            end
            if (oDone != 0) dn++;
        end
        chk("t2_acks", 32'(n), 5);
        chk("t2_dones", 32'(dn), 5);
        for (int i = 0; i < 5; i++) chk("t2_order", 32'(order[i]), 32'(exp2[i]));
        auto_drop = 1'b1;
        step(); step();

        // zero-length descriptor on channel 2
        set_desc(2, 32'h3000, 32'h4000, 32'd0);
        iReq = 4'b0100;
        step();
        chk("t3_ack", 32'(oAck), 32'h4);
        chk("t3_nostart_a", 32'(oStart), 0);
        step();
        chk("t3_done", 32'(oDone), 32'h4);
        chk("t3_nostart_b", 32'(oStart), 0);
        step();
        chk("t3_idle", 32'(oBusy), 0);

        // stray engine done while idle, and a request withdrawn before ack
        eng_en = 1'b0; iWM_done = 1'b1;
        step();
        iWM_done = 1'b0;
        chk("t4_stray_busy", 32'(oBusy), 0);
        chk("t4_stray_done", 32'(oDone), 0);
        step();
        chk("t4_stray_done2", 32'(oDone), 0);
        eng_en = 1'b1; eng_lat = 8; a1 = 0;
        set_desc(3, 32'h7000, 32'h7800, 32'd20);
        iReq = 4'b1000;
        step();
        chk("t4_ack3", 32'(oAck), 32'h8);
        iReq[1] = 1'b1;
        step(); step(); step();
        if (oAck[1]) a1++;
        iReq[1] = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (oAck[1]) a1++;
            if (oDone != 0) break;
        end
        chk("t4_done3", 32'(oDone), 32'h8);
        for (int i = 0; i < 3; i++) begin
            step();
            if (oAck[1]) a1++;
        end
        chk("t4_ch1_never", 32'(a1), 0);

        // reset in the middle of RUN, then a fresh arbitration
        set_desc(1, 32'h5000, 32'h6000, 32'd100);
        eng_lat = 50;
        iReq = 4'b0010;
        step();
        step();
        chk("t5_run", 32'(oStart), 1);
        step(); step(); step();
        iReset = 1'b1;
        step();
        chk("t5_start", 32'(oStart), 0);
        chk("t5_busy", 32'(oBusy), 0);
        chk("t5_done", 32'(oDone), 0);
        iReset = 1'b0;
        eng_lat = 4;
        set_desc(0, 32'hA000, 32'hB000, 32'd32);
        set_desc(1, 32'hC000, 32'hD000, 32'd48);
        iReq = 4'b0011;
        step();
        chk("t5_first", 32'(oAck), 32'h1);
        dn = 0; seen = '0;
        for (int i = 0; i < 100 && dn < 2; i++) begin
            step();
            seen = seen | oAck;
            if (oDone != 0) dn++;
        end
        chk("t5_second", 32'(seen), 32'h2);
        chk("t5_dones", 32'(dn), 2);

`ifdef DMA_SCHED_TIMEOUT_EN
        // watchdog: engine never finishes
        do_reset();
        eng_en = 1'b0; iWM_done = 1'b0;
        set_desc(0, 32'h11, 32'h22, 32'd8);
        set_desc(1, 32'h33, 32'h44, 32'd8);
        iReq = 4'b0011;
        t_s = -1; t_to = -1;
        for (int i = 0; i < 60; i++) begin
            step();
            if (oStart && t_s < 0) t_s = cyc;
            if (oTimeout != 0) begin
                t_to = cyc;
                break;
            end
        end
        chk("t6_to", 32'(oTimeout), 32'h1);
        chk("t6_start_drop", 32'(oStart), 0);
        chk("t6_to_lat", 32'(t_to - t_s), 32'd20);
        step();
        chk("t6_next", 32'(oAck), 32'h2);
        for (int i = 0; i < 60; i++) begin
            step();
            if (oTimeout != 0) break;
        end
        chk("t6_to2", 32'(oTimeout), 32'h2);
`endif

        step(); step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
